wb_sram_port0_ctrl: RTL
=======================

# wb_sram_port0_ctrl

Wishbone B4 classic slave that bridges the management SoC bus onto the read/write port (port 0) of the 512×32 dual-port SRAM macro. It sits directly upstream of the macro:
- decodes the bus address;
- converts `wb_sel_i` into the per-byte write mask;
- sequences the macro's registered-input, negedge-access protocol;
- returns read data and a single-cycle `ack`/`err` to the bus.

Port 1 of the macro is not driven by this block.

## Interface
Parameters:
- BASE_ADDR, 32'h0100_0000: byte base address of the SRAM window. Must be aligned to the 2 KB window size.
- ADDR_WIDTH, 9: SRAM word-address width.
- DATA_WIDTH, 32: data width.
- NUM_WMASKS, 4: byte-lane count, equal to DATA_WIDTH/8.

Ports:
- wb_clk_i  in  1  single clock; it also drives the macro's `clk0`.
- wb_rstn_i  in  1  asynchronous, active-low reset.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  write enable.
- wb_sel_i  in  4  byte selects.
- wb_adr_i  in  32  byte address.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  transfer acknowledge.
- wb_err_o  out  1  out-of-window error.
- sram_csb0  out  1  macro chip select, active low.
- sram_web0  out  1  macro write enable, active low.
- sram_wmask0  out  4  macro byte write mask.
- sram_addr0  out  9  macro word address.
- sram_din0  out  32  macro write data.
- sram_dout0  in  32  macro read data.

## Operation
- Address decode:
  - Hit when `wb_adr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]`.
  - Word index is `wb_adr_i[ADDR_WIDTH+1:2]`.
  - `wb_adr_i[1:0]` is ignored.
- States: IDLE, ISSUE, RD_WAIT, ACK, ERR.
- IDLE:
  - On `cyc & stb` with a hit: register `sram_csb0`=0, `sram_web0`=!`we`, `sram_addr0`, `sram_din0` and `sram_wmask0`; go to ISSUE.
    - For writes, `sram_wmask0` = `wb_sel_i`.
    - For reads, `sram_wmask0` = 4'h0.
  - On `cyc & stb` with a miss: go to ERR. No macro access is made.
- ISSUE:
  - The macro samples its inputs at this edge.
  - `sram_csb0` returns to 1 and `sram_web0` to 1.
  - Write: go to ACK.
  - Read: go to RD_WAIT.
- RD_WAIT: latch `sram_dout0` into `wb_dat_o`, then go to ACK.
- ACK: `wb_ack_o`=1 for exactly one cycle, then IDLE.
- ERR: `wb_err_o`=1 for exactly one cycle, then IDLE.
- Write with `wb_sel_i`=0: the macro is still accessed with mask 0, which leaves memory unchanged, and the transfer is acked.
- Abort: if `wb_cyc_i` falls while in ISSUE or RD_WAIT:
  - go to IDLE with no `ack`;
  - a write already sampled by the macro still completes.
- `wb_dat_o` holds its last read value until the next read completes. It is not cleared on writes.
- All outputs are registered. No combinational path exists from `wb_*` inputs to `wb_*` or `sram_*` outputs.

## Timing
- Reset (asynchronous, `wb_rstn_i`=0):
  - state IDLE;
  - `sram_csb0`=1, `sram_web0`=1;
  - `sram_wmask0`=0, `sram_addr0`=0, `sram_din0`=0;
  - `wb_dat_o`=0, `wb_ack_o`=0, `wb_err_o`=0.
- Reset mid-transfer: `sram_csb0` deasserts immediately and any pending `ack` is dropped.
- Edge numbering: E0 is the first edge at which `cyc & stb` is sampled high in IDLE.
- `sram_csb0` is low for exactly one cycle, E0–E1. The macro samples at E1.
- Write: `wb_ack_o` is high E1–E2. Bus latency is 2 cycles; 3 cycles per transfer including the return to IDLE.
- Read: `sram_dout0` is sampled only at E2, never at any other edge. `wb_ack_o` and valid `wb_dat_o` are high E2–E3. Bus latency is 3 cycles; 4 cycles per transfer.
- Error: `wb_err_o` is high E0–E1.
- A `stb` still high at the ACK/ERR edge is not re-accepted. The request is re-evaluated in IDLE on the next edge.

## Structure
- Package `wb_sram_pkg`: the state enum, ADDR_WIDTH/DATA_WIDTH/NUM_WMASKS constants, and the default BASE_ADDR.
- Single module with no sub-modules.
- The address decode is a local function in the package, reusable by a future port-1 controller.

## Test plan
- Reset: hold `wb_rstn_i`=0 → all outputs at their reset values and `sram_csb0`=1; release → no macro access until a request arrives.
- Write 0xDEADBEEF to BASE+0x10 with sel=4'hF, then read BASE+0x10 → write ack at E1–E2, `sram_addr0`=4, read ack at E2–E3 with `wb_dat_o`=0xDEADBEEF.
- Byte write: write 0x000000AA, sel=4'h1, over 0x11223344 at BASE+0x7FC → `sram_addr0`=511, `wmask0`=4'h1, read-back 0x112233AA.
- Out-of-window read at BASE+0x800 → `err` at E0–E1, no `ack`, `sram_csb0` stays 1.
- Abort: drop `cyc` in RD_WAIT → no `ack`, FSM back in IDLE, and the next read to BASE+0x10 returns correct data.
- Async reset asserted in ISSUE during a write → `sram_csb0`=1 immediately, no `ack`, next transfer normal.

Source files
------------

// File: rtl/wb_sram_pkg.sv
// Shared definitions for the Wishbone-to-SRAM port controllers: geometry,
// default window base, FSM state type and the window address decode.
package wb_sram_pkg;

  localparam int unsigned SRAM_ADDR_WIDTH = 9;
  localparam int unsigned SRAM_DATA_WIDTH = 32;
  localparam int unsigned SRAM_NUM_WMASKS = SRAM_DATA_WIDTH / 8;
  localparam logic [31:0] SRAM_BASE_ADDR  = 32'h0100_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RD_WAIT,
    ST_ACK,
    ST_ERR
  } state_t;

  // Hit when every address bit above the word index matches the window base.
  function automatic logic addr_hit(input logic [31:0] adr,
                                    input logic [31:0] base,
                                    input int unsigned aw);
    return (adr >> (aw + 2)) == (base >> (aw + 2));
  endfunction

endpackage

// File: rtl/wb_sram_port0_ctrl.sv
// Wishbone B4 classic slave driving the read/write port 0 of the 512x32
// dual-port SRAM macro; all bus and macro outputs are registered.
module wb_sram_port0_ctrl
  import wb_sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = SRAM_BASE_ADDR,
  parameter int unsigned ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int unsigned NUM_WMASKS = SRAM_NUM_WMASKS
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rstn_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [NUM_WMASKS-1:0] wb_sel_i,
  input  logic [31:0]           wb_adr_i,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  state_t state;
  logic   we_q;
  logic   hit;

  assign hit = addr_hit(wb_adr_i, BASE_ADDR, ADDR_WIDTH);

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state       <= ST_IDLE;
      we_q        <= 1'b0;
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
      wb_dat_o    <= '0;
      wb_ack_o    <= 1'b0;
      wb_err_o    <= 1'b0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            if (hit) begin
              sram_csb0   <= 1'b0;
              sram_web0   <= !wb_we_i;
              sram_addr0  <= wb_adr_i[ADDR_WIDTH+1:2];
              sram_din0   <= wb_dat_i;
              sram_wmask0 <= wb_we_i ? wb_sel_i : '0;
              we_q        <= wb_we_i;
              state       <= ST_ISSUE;
            end else begin
              wb_err_o <= 1'b1;
              state    <= ST_ERR;
            end
          end
        end
        ST_ISSUE: begin
          // The macro captures the request at this edge, so an abort here
          // cannot cancel a write; it only suppresses the bus response.
          sram_csb0 <= 1'b1;
          sram_web0 <= 1'b1;
          if (!wb_cyc_i) begin
            state <= ST_IDLE;
          end else if (!we_q) begin
            state <= ST_RD_WAIT;
          end else begin
            wb_ack_o <= 1'b1;
            state    <= ST_ACK;
          end
        end
        ST_RD_WAIT: begin
          if (!wb_cyc_i) begin
            state <= ST_IDLE;
          end else begin
            wb_dat_o <= sram_dout0;
            wb_ack_o <= 1'b1;
            state    <= ST_ACK;
          end
        end
        ST_ACK:  state <= ST_IDLE;
        ST_ERR:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
